// File: rtl/branch_compare_sequencer.sv
// ---------------------------------------------------------------------------
// branch_compare_sequencer
//
// Evaluates a RISC-V conditional-branch decision on two 64-bit operands.
// One 32-bit subtractor is shared by both halves: the low halves are
// subtracted first and the carry is chained into the high halves on the
// next cycle. The result is held in registers until the consumer takes it.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   in_valid   in   1   request present on A, B, funct3
//   in_ready   out  1   sequencer idle and able to accept a request
//   A, B       in   64  operands rs1, rs2
//   funct3     in   3   branch code (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   flush      in   1   synchronous abort of any in-flight compare
//   out_valid  out  1   result registers valid
//   out_ready  in   1   consumer takes the result
//   taken      out  1   branch decision (0 for illegal codes)
//   eq         out  1   A == B
//   lt         out  1   signed A < B
//   ltu        out  1   unsigned A < B
//   illegal    out  1   funct3 is 010 or 011
// ---------------------------------------------------------------------------
module branch_compare_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [2:0]  funct3,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        taken,
  output logic        eq,
  output logic        lt,
  output logic        ltu,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] a_q, b_q;
  logic [2:0]  f3_q;
  logic        c_lo_q, zero_lo_q;
  logic        taken_q, eq_q, lt_q, ltu_q, illegal_q;

  logic        accept, lo_en, res_en;

  // Shared subtractor: a - b computed as a + ~b + cin.
  logic [31:0] a_half, b_half;
  logic        cin;
  logic [32:0] sum;
  logic        carry, zero;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_half = a_q[31:0];
    b_half = b_q[31:0];
    cin    = 1'b1;
    if (state_q == HI) begin
      a_half = a_q[63:32];
      b_half = b_q[63:32];
      cin    = c_lo_q;
    end
  end

  assign sum   = {1'b0, a_half} + {1'b0, ~b_half} + {32'd0, cin};
  assign carry = sum[32];
  assign zero  = (sum[31:0] == 32'd0);

  // Final decision, valid while the high half is on the subtractor.
  logic eq_d, lt_d, ltu_d, illegal_d, taken_d;

  always_comb begin
    eq_d      = zero_lo_q & zero;
    ltu_d     = ~carry;  // carry out set means no borrow, i.e. A >= B
    // Differing signs decide signed order directly; otherwise unsigned order holds.
    lt_d      = (a_q[63] ^ b_q[63]) ? a_q[63] : ltu_d;
    illegal_d = (f3_q == 3'b010) || (f3_q == 3'b011);
    taken_d   = 1'b0;
    case (f3_q)
      3'b000:  taken_d = eq_d;
      3'b001:  taken_d = ~eq_d;
      3'b100:  taken_d = lt_d;
      3'b101:  taken_d = ~lt_d;
      3'b110:  taken_d = ltu_d;
      3'b111:  taken_d = ~ltu_d;
      default: taken_d = 1'b0;
    endcase
  end

  // Next-state logic. flush overrides everything, including acceptance.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    lo_en   = 1'b0;
    res_en  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          accept  = 1'b1;
          state_d = LO;
        end
        LO: begin
          lo_en   = 1'b1;
          state_d = HI;
        end
        HI: begin
          res_en  = 1'b1;
          state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers are reset too, so outputs read as zero after reset
  // rather than carrying a previous result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      c_lo_q    <= 1'b0;
      zero_lo_q <= 1'b0;
      taken_q   <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        f3_q <= funct3;
      end
      if (lo_en) begin
        c_lo_q    <= carry;
        zero_lo_q <= zero;
      end
      // Result outputs move only on entry to DONE.
      if (res_en) begin
        taken_q   <= taken_d & ~illegal_d;
        eq_q      <= eq_d;
        lt_q      <= lt_d;
        ltu_q     <= ltu_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign taken     = taken_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_branch_compare_sequencer.sv
// ---------------------------------------------------------------------------
// tb_branch_compare_sequencer
//
// Directed and randomized checks of the branch compare sequencer against a
// plain 64-bit arithmetic model of the branch rules. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_branch_compare_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A, B;
  logic [2:0]  funct3;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        taken, eq, lt, ltu, illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_compare_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .funct3    (funct3),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .eq        (eq),
    .lt        (lt),
    .ltu       (ltu),
    .illegal   (illegal)
  );

  // Result vector ordering: {taken, eq, lt, ltu, illegal}
  function automatic logic [4:0] res_vec();
    return {taken, eq, lt, ltu, illegal};
  endfunction

  // Behavioural model: whole-word comparisons, no half splitting.
  function automatic logic [4:0] model(input logic [63:0] a, input logic [63:0] b,
                                       input logic [2:0] f);
    logic e, s, u, il, t;
    e  = (a == b);
    u  = (a < b);
    s  = ($signed(a) < $signed(b));
    il = (f == 3'b010) || (f == 3'b011);
    case (f)
      3'b000:  t = e;
      3'b001:  t = !e;
      3'b100:  t = s;
      3'b101:  t = !s;
      3'b110:  t = u;
      3'b111:  t = !u;
      default: t = 1'b0;
    endcase
    return {t, e, s, u, il};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in IDLE. hold = cycles of out_ready low in
  // DONE; flush_exit leaves DONE with flush and out_ready both high.
  task automatic do_compare(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] f, input logic [4:0] exp, input int hold,
                            input bit flush_exit);
    check({tag, "_idle_ready"}, in_ready, 1);
    A = a; B = b; funct3 = f; in_valid = 1'b1;
    step();  // acceptance edge k
    in_valid = 1'b0;
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; funct3 = 3'($urandom);
    check({tag, "_busy_ready"}, in_ready, 0);
    check({tag, "_valid_k0"}, out_valid, 0);
    step();  // k+1
    check({tag, "_valid_k1"}, out_valid, 0);
    step();  // k+2
    check({tag, "_valid_k2"}, out_valid, 1);
    check({tag, "_res"}, res_vec(), exp);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
      check({tag, "_hold_res"}, res_vec(), exp);
    end
    // A request offered in DONE must not be taken even while out_ready is high.
    out_ready = 1'b1; in_valid = 1'b1; flush = flush_exit;
    step();
    out_ready = 1'b0; in_valid = 1'b0; flush = 1'b0;
    check({tag, "_exit_valid"}, out_valid, 0);
    check({tag, "_exit_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [63:0] a, b;
    logic [2:0]  f;

    reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; funct3 = '0;
    flush = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_res", res_vec(), 5'b00000);
    step();
    reset = 1'b0;
    step();

    // BEQ, equal operands with only the high half non-zero
    do_compare("beq", 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 3'b000,
               5'b11000, 0, 1'b0);
    // Carry chain across the halves, then swapped
    do_compare("bltu_gt", 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 3'b110,
               5'b00000, 0, 1'b0);
    do_compare("bltu_lt", 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 3'b110,
               5'b10110, 0, 1'b0);
    // Signed versus unsigned ordering
    do_compare("blt_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b100, 5'b10100, 0, 1'b0);
    do_compare("bgeu_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b111, 5'b10100, 0, 1'b0);
    // Illegal code under backpressure
    do_compare("illegal", 64'h5, 64'h5, 3'b010, 5'b01001, 5, 1'b0);

    // Flush while in HI: no result, results stay as before
    A = 64'h9; B = 64'h3; funct3 = 3'b001; in_valid = 1'b1;
    step();  // accepted, now LO
    in_valid = 1'b0;
    step();  // now HI
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_hi_ready", in_ready, 1);
    check("flush_hi_valid", out_valid, 0);
    check("flush_hi_stale", res_vec(), 5'b01001);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_hi_quiet", out_valid, 0);
    end

    // Flush beats in_valid in IDLE
    flush = 1'b1; in_valid = 1'b1; A = 64'h1; B = 64'h2; funct3 = 3'b100;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_ready", in_ready, 1);
    step();
    step();
    check("flush_idle_valid", out_valid, 0);

    // flush together with out_ready in DONE consumes the result
    do_compare("flush_done", 64'h7, 64'h8, 3'b101, 5'b00110, 1, 1'b1);

    // Reset in LO clears outputs immediately and discards the request
    do_compare("pre_rst", 64'h3, 64'h3, 3'b000, 5'b11000, 0, 1'b0);
    A = 64'h10; B = 64'h20; funct3 = 3'b110; in_valid = 1'b1;
    step();  // accepted, now LO
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_lo_ready", in_ready, 1);
    check("rst_lo_valid", out_valid, 0);
    check("rst_lo_res", res_vec(), 5'b00000);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_lo_quiet", out_valid, 0);
    end
    // First edge with in_valid after reset accepts
    do_compare("post_rst", 64'h20, 64'h10, 3'b111, 5'b10000, 0, 1'b0);

    // Random sweep: one operand's low and high byte walk all 256 values,
    // remaining bits random, with some equal halves forced for eq/carry edges.
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 256; k++) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        if (pass == 0) begin
          a[7:0]   = k[7:0];
          a[63:56] = k[7:0] ^ 8'h5A;
        end else begin
          b[7:0]   = k[7:0];
          b[63:56] = k[7:0] ^ 8'hA5;
        end
        case (k[1:0])
          2'd1:    if (pass == 0) b = a; else a = b;
          2'd2:    b[31:0]  = a[31:0];
          2'd3:    b[63:32] = a[63:32];
          default: ;
        endcase
        f = 3'(k >> 2);
        do_compare("sweep", a, b, f, model(a, b, f), k % 3, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
